// File: rtl/imem_sequencer.sv
// rtl/imem_sequencer.sv - program loader, instruction store and fetch/debug read arbiter
// Holds the core in reset while a byte stream is loaded, then serves pc fetches and debug reads.
module imem_sequencer #(
  parameter int         DEPTH = 32,
  parameter int         AW    = 5,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic          origclk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_reset,
  input  logic [7:0]    pc,
  output logic [7:0]    instruction,
  output logic          fetch_valid,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_valid,
  output logic [7:0]    dbg_data,
  output logic [AW:0]   load_count,
  output logic          err_overflow
);

  localparam int          RAW       = 9;
  localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_mem [DEPTH];
  logic [AW:0]    r_load_count;
  logic           r_err_overflow;
  logic           r_dbg_prio;
  logic [7:0]     r_instruction;
  logic           r_fetch_valid;
  logic           r_dbg_valid;
  logic [7:0]     r_dbg_data;

  logic           w_accept;
  logic           w_load_entry;
  logic           w_last_slot;
  logic           w_grant_cpu;
  logic           w_grant_dbg;
  logic [RAW-1:0] w_rd_addr;
  logic [7:0]     w_rd_data;

  assign w_last_slot = (r_load_count == LAST_SLOT);

  always_comb begin
    w_state_nxt  = r_state;
    ld_ready     = 1'b0;
    cpu_reset    = 1'b1;
    w_accept     = 1'b0;
    w_load_entry = 1'b0;
    w_grant_cpu  = 1'b0;
    w_grant_dbg  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_LOAD;
          w_load_entry = 1'b1;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        w_accept = ld_valid;
        if (ld_valid && (ld_last || w_last_slot)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        // The core asks every cycle, so debug wins only when it is owed the turn.
        w_grant_dbg = dbg_req & r_dbg_prio;
        w_grant_cpu = ~w_grant_dbg;
        if (start) begin
          w_state_nxt  = S_LOAD;
          w_load_entry = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_addr = w_grant_dbg ? RAW'(dbg_addr) : RAW'(pc);
  // Bytes past the current load are stale leftovers from an earlier program.
  assign w_rd_data = (w_rd_addr < RAW'(r_load_count)) ? r_mem[w_rd_addr[AW-1:0]] : FILL;

  always_ff @(posedge origclk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge origclk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= FILL;
      end
    end else if (w_accept) begin
      r_mem[r_load_count[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge origclk) begin
    if (!reset) begin
      r_load_count   <= '0;
      r_err_overflow <= 1'b0;
      r_dbg_prio     <= 1'b0;
    end else if (w_load_entry) begin
      r_load_count   <= '0;
      r_err_overflow <= 1'b0;
      r_dbg_prio     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_load_count <= r_load_count + 1'b1;
        if (w_last_slot && !ld_last) begin
          r_err_overflow <= 1'b1;
        end
      end
      if (r_state == S_RUN && dbg_req) begin
        r_dbg_prio <= ~w_grant_dbg;
      end
    end
  end

  always_ff @(posedge origclk) begin
    if (!reset) begin
      r_instruction <= FILL;
      r_fetch_valid <= 1'b0;
      r_dbg_valid   <= 1'b0;
      r_dbg_data    <= 8'h00;
    end else begin
      r_fetch_valid <= w_grant_cpu;
      r_dbg_valid   <= w_grant_dbg;
      if (w_grant_cpu) begin
        r_instruction <= w_rd_data;
      end
      if (w_grant_dbg) begin
        r_dbg_data <= w_rd_data;
      end
    end
  end

  assign instruction  = r_instruction;
  assign fetch_valid  = r_fetch_valid;
  assign dbg_valid    = r_dbg_valid;
  assign dbg_data     = r_dbg_data;
  assign load_count   = r_load_count;
  assign err_overflow = r_err_overflow;

endmodule
